// File: rtl/cc_rdata_if.sv
// Line-in / AXI-R-out bundle for the cache-controller read-data serializer.
// The slave modport is the serializer side; the master modport drives lines and rready.
interface cc_rdata_if #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned BEATS    = 8,
    parameter int unsigned OFFSET_W = 3
) ();
    localparam int unsigned LINE_W = DATA_W * BEATS;

    logic                line_valid_i;
    logic [LINE_W-1:0]   line_data_i;
    logic [OFFSET_W-1:0] line_offset_i;
    logic                line_ready_o;
    logic [DATA_W-1:0]   inct_rdata_o;
    logic [1:0]          inct_rresp_o;
    logic                inct_rlast_o;
    logic                inct_rvalid_o;
    logic                inct_rready_i;
    logic                busy_o;

    modport slave (
        input  line_valid_i, line_data_i, line_offset_i, inct_rready_i,
        output line_ready_o, inct_rdata_o, inct_rresp_o, inct_rlast_o, inct_rvalid_o, busy_o
    );

    modport master (
        output line_valid_i, line_data_i, line_offset_i, inct_rready_i,
        input  line_ready_o, inct_rdata_o, inct_rresp_o, inct_rlast_o, inct_rvalid_o, busy_o
    );
endinterface

// File: rtl/cc_rdata_serializer.sv
// Serializes one cache line into BEATS AXI R beats, critical word first with wrap-around.
// CC_RDATA_BUBBLE_FREE_EN: accept the next line during the last-beat handshake (no idle gap).
module cc_rdata_serializer #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned BEATS    = 8,
    parameter int unsigned OFFSET_W = 3
) (
    input  logic       clk,
    input  logic       rst,
    cc_rdata_if.slave  bus
);
    localparam int unsigned LAST_BEAT = BEATS - 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    state_e                         state_q, state_d;
    logic [OFFSET_W-1:0]            beat_cnt_q, beat_cnt_d;
    logic [OFFSET_W-1:0]            offset_q, offset_d;
    logic [BEATS-1:0][DATA_W-1:0]   line_q, line_d;

    logic [OFFSET_W-1:0]            word_idx;
    logic                           send;
    logic                           last_beat;
    logic                           beat_hs;
    logic                           line_ready_c;
    logic                           accept;

    // State register; reset also discards any buffered line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            offset_q   <= '0;
            line_q     <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            offset_q   <= offset_d;
            line_q     <= line_d;
        end
    end

    assign send      = (state_q == ST_SEND);
    assign word_idx  = offset_q + beat_cnt_q;  // OFFSET_W-bit sum wraps naturally
    assign last_beat = send && (beat_cnt_q == OFFSET_W'(LAST_BEAT));
    assign beat_hs   = send && bus.inct_rready_i;

`ifdef CC_RDATA_BUBBLE_FREE_EN
    assign line_ready_c = !send || (last_beat && bus.inct_rready_i);
`else
    assign line_ready_c = !send;
`endif

    assign accept = bus.line_valid_i && line_ready_c;

    // Next-state: load on accept, advance on beat handshake, reload or idle after last beat
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        offset_d   = offset_q;
        line_d     = line_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    line_d     = bus.line_data_i;
                    offset_d   = bus.line_offset_i;
                    beat_cnt_d = '0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (beat_hs) begin
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        if (accept) begin
                            line_d   = bus.line_data_i;
                            offset_d = bus.line_offset_i;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + OFFSET_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // R channel is a mux of registered state only; data is zeroed outside a burst
    assign bus.inct_rvalid_o = send;
    assign bus.inct_rdata_o  = send ? line_q[word_idx] : '0;
    assign bus.inct_rlast_o  = last_beat;
    assign bus.inct_rresp_o  = 2'b00;
    assign bus.busy_o        = send;
    assign bus.line_ready_o  = line_ready_c;

endmodule

// File: tb/tb_cc_rdata_serializer.sv
// Randomized + directed bench for cc_rdata_serializer against a queue-based beat model.
module tb_cc_rdata_serializer;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned BEATS    = 8;
    localparam int unsigned OFFSET_W = 3;
    localparam int unsigned LINE_W   = DATA_W * BEATS;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              last;
    } beat_t;

    typedef struct packed {
        logic [LINE_W-1:0]   d;
        logic [OFFSET_W-1:0] off;
    } line_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cc_rdata_if #(.DATA_W(DATA_W), .BEATS(BEATS), .OFFSET_W(OFFSET_W)) bus_if ();

    cc_rdata_serializer #(.DATA_W(DATA_W), .BEATS(BEATS), .OFFSET_W(OFFSET_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_beats  = 0;
    beat_t bq[$];   // expected beats still owed by the DUT
    line_t lq[$];   // upstream FIFO of lines waiting to be accepted

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [LINE_W-1:0] make_line(input logic [DATA_W-1:0] base);
        logic [LINE_W-1:0] l;
        for (int i = 0; i < int'(BEATS); i++) l[DATA_W*i +: DATA_W] = base + DATA_W'(i);
        return l;
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int i = 0; i < int'(LINE_W / 32); i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    task automatic push_line(input logic [LINE_W-1:0] d, input logic [OFFSET_W-1:0] off);
        line_t ln;
        ln.d   = d;
        ln.off = off;
        lq.push_back(ln);
    endtask

    // Critical-word-first order: beat k carries word (offset + k) mod BEATS
    task automatic expect_line(input line_t ln);
        beat_t b;
        int    idx;
        for (int k = 0; k < int'(BEATS); k++) begin
            idx    = (int'(ln.off) + k) % int'(BEATS);
            b.d    = ln.d[DATA_W*idx +: DATA_W];
            b.last = (k == int'(BEATS) - 1);
            bq.push_back(b);
        end
    endtask

    // One clock: drive at negedge, check #1 later, advance the model at posedge
    task automatic cycle(input bit rr);
        bit exp_valid, exp_ready, hs, acc;
        bus_if.line_valid_i  = (lq.size() > 0);
        bus_if.line_data_i   = (lq.size() > 0) ? lq[0].d : '0;
        bus_if.line_offset_i = (lq.size() > 0) ? lq[0].off : '0;
        bus_if.inct_rready_i = rr;
        #1;
        exp_valid = (bq.size() > 0);
`ifdef CC_RDATA_BUBBLE_FREE_EN
        exp_ready = (bq.size() == 0) || (bq.size() == 1 && rr);
`else
        exp_ready = (bq.size() == 0);
`endif
        check("rvalid", 64'(bus_if.inct_rvalid_o), 64'(exp_valid));
        check("busy", 64'(bus_if.busy_o), 64'(exp_valid));
        check("line_ready", 64'(bus_if.line_ready_o), 64'(exp_ready));
        check("rresp", 64'(bus_if.inct_rresp_o), 64'd0);
        if (exp_valid) begin
            check("rdata", bus_if.inct_rdata_o, bq[0].d);
            check("rlast", 64'(bus_if.inct_rlast_o), 64'(bq[0].last));
        end else begin
            check("rlast_idle", 64'(bus_if.inct_rlast_o), 64'd0);
        end
        hs  = exp_valid && rr;
        acc = (lq.size() > 0) && exp_ready;
        @(posedge clk);
        if (hs) begin
            void'(bq.pop_front());
            n_beats++;
        end
        if (acc) begin
            expect_line(lq[0]);
            void'(lq.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic run_until_idle(input int max_cycles, input int rr_pct, output int used);
        used = 0;
        while ((bq.size() > 0 || lq.size() > 0) && used < max_cycles) begin
            cycle($urandom_range(99) < rr_pct);
            used++;
        end
        if (bq.size() > 0 || lq.size() > 0)
            check("timeout_pending", 64'(bq.size() + lq.size()), 64'd0);
    endtask

    // Asynchronous reset between clock edges; outputs must drop before the next edge
    task automatic mid_cycle_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_rvalid", 64'(bus_if.inct_rvalid_o), 64'd0);
        check("rst_rlast", 64'(bus_if.inct_rlast_o), 64'd0);
        check("rst_rdata", bus_if.inct_rdata_o, 64'd0);
        check("rst_line_ready", 64'(bus_if.line_ready_o), 64'd1);
        check("rst_busy", 64'(bus_if.busy_o), 64'd0);
        bq.delete();
        lq.delete();
        bus_if.line_valid_i  = 1'b0;
        bus_if.inct_rready_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int used;
        bus_if.line_valid_i  = 1'b0;
        bus_if.line_data_i   = '0;
        bus_if.line_offset_i = '0;
        bus_if.inct_rready_i = 1'b0;

        // Power-on reset values
        @(negedge clk);
        check("por_rvalid", 64'(bus_if.inct_rvalid_o), 64'd0);
        check("por_rdata", bus_if.inct_rdata_o, 64'd0);
        check("por_line_ready", 64'(bus_if.line_ready_o), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // rready in IDLE does nothing
        for (int i = 0; i < 3; i++) cycle(1'b1);

        // Offset 0 then wrap from offset 6
        push_line(make_line(64'h1000), 3'd0);
        run_until_idle(40, 100, used);
        check("burst_off0_cycles", 64'(used), 64'd9);
        push_line(make_line(64'h1000), 3'd6);
        run_until_idle(40, 100, used);
        check("burst_off6_cycles", 64'(used), 64'd9);

        // Backpressure at beat 2 of an offset-3 line (word 1005 must hold)
        push_line(make_line(64'h1000), 3'd3);
        for (int i = 0; i < 3; i++) cycle(1'b1);
        check("bp_head", bq[0].d, 64'h1005);
        for (int i = 0; i < 4; i++) cycle(1'b0);
        run_until_idle(40, 100, used);

        // Back-to-back lines A (offset 0) and B (offset 7)
        n_beats = 0;
        push_line(make_line(64'hA000), 3'd0);
        push_line(make_line(64'hB000), 3'd7);
        run_until_idle(60, 100, used);
`ifdef CC_RDATA_BUBBLE_FREE_EN
        check("b2b_cycles", 64'(used), 64'd17);
`else
        check("b2b_cycles", 64'(used), 64'd18);
`endif
        check("b2b_beats", 64'(n_beats), 64'd16);

        // Abort at beat 4, then a fresh offset-2 line
        push_line(make_line(64'hC000), 3'd0);
        for (int i = 0; i < 5; i++) cycle(1'b1);
        mid_cycle_reset();
        for (int i = 0; i < 2; i++) cycle(1'b1);
        n_beats = 0;
        push_line(make_line(64'hD000), 3'd2);
        run_until_idle(40, 100, used);
        check("abort_new_beats", 64'(n_beats), 64'd8);
        for (int i = 0; i < 2; i++) cycle(1'b1);

        // Randomized lines, offsets and rready
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(3) == 0 && lq.size() < 3)
                push_line(rand_line(), OFFSET_W'($urandom_range(BEATS - 1)));
            cycle($urandom_range(99) < 70);
        end
        run_until_idle(300, 70, used);

        // Saturated random traffic to exercise back-to-back reloads
        for (int i = 0; i < 6; i++) push_line(rand_line(), OFFSET_W'($urandom_range(BEATS - 1)));
        run_until_idle(200, 100, used);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
